// File: rtl/video_source_scheduler_if.sv
// -----------------------------------------------------------------------------
// video_source_scheduler_if
//   Groups the pixel-stream, source handshake and status signals of the
//   video source scheduler.
//
//   master : scheduler side. Takes the display, source and control inputs and
//            drives the pixel, strobes and status flags.
//   slave  : environment side (display stage, pattern generator, frame-buffer
//            reader and control logic).
//
//   Signals
//     VideoReady      display consumes the video pixel this cycle
//     PatVideo[23:0]  pixel from the pattern generator (RGB 8:8:8)
//     FbVideo[23:0]   pixel from the frame-buffer reader
//     FbValid         FbVideo holds a valid pixel
//     FbRequest       level request for the frame buffer to own the display
//     ClearUnderflow  one-cycle pulse that clears Underflow
//     video[23:0]     pixel to the display
//     PatReady        advance strobe to the pattern generator
//     PatRestart      restart pulse to the pattern generator
//     FbReady         pop strobe to the frame-buffer reader
//     FbGrant         frame buffer owns the display
//     FrameStart      raster is at pixel (0,0)
//     Underflow       sticky frame-buffer underflow flag
//     FrameCount      completed-frame counter
// -----------------------------------------------------------------------------
interface video_source_scheduler_if;
    logic        VideoReady;
    logic [23:0] PatVideo;
    logic [23:0] FbVideo;
    logic        FbValid;
    logic        FbRequest;
    logic        ClearUnderflow;
    logic [23:0] video;
    logic        PatReady;
    logic        PatRestart;
    logic        FbReady;
    logic        FbGrant;
    logic        FrameStart;
    logic        Underflow;
    logic [15:0] FrameCount;

    modport master (
        input  VideoReady, PatVideo, FbVideo, FbValid, FbRequest, ClearUnderflow,
        output video, PatReady, PatRestart, FbReady, FbGrant, FrameStart,
               Underflow, FrameCount
    );

    modport slave (
        output VideoReady, PatVideo, FbVideo, FbValid, FbRequest, ClearUnderflow,
        input  video, PatReady, PatRestart, FbReady, FbGrant, FrameStart,
               Underflow, FrameCount
    );
endinterface

// File: rtl/video_source_scheduler.sv
// -----------------------------------------------------------------------------
// video_source_scheduler
//   Shares the display pixel stream between the test-pattern generator (P) and
//   the frame-buffer reader (F). Tracks the raster position from VideoReady and
//   hands ownership over only at frame boundaries, so every frame comes
//   entirely from one source. Flags frame-buffer underflow (sticky).
//
//   Ports
//     Clock   system clock, rising edge
//     Reset   asynchronous active-low reset
//     bus     video_source_scheduler_if.master (pixel stream, strobes, status)
//
//   Parameters
//     H_ACTIVE / V_ACTIVE  active pixels per line / lines per frame
//     XW / YW              column / row counter widths
//     FILL_COLOR           pixel shown when F owns the display but has no data
// -----------------------------------------------------------------------------
module video_source_scheduler #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 10,
    parameter logic [23:0] FILL_COLOR = 24'h000000
) (
    input logic                      Clock,
    input logic                      Reset,
    video_source_scheduler_if.master bus
);

    // S_TO_FB / S_TO_PAT are hand-over states: the current owner keeps the
    // display until end of frame while the request is watched.
    typedef enum logic [1:0] {
        S_PAT    = 2'd0,
        S_TO_FB  = 2'd1,
        S_FB     = 2'd2,
        S_TO_PAT = 2'd3
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    state_t        state;
    state_t        next_state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   frame_count;
    logic          underflow;
    logic          fb_grant;
    logic          pat_restart;
    logic          x_last;
    logic          eof;
    logic          underflow_set;

    assign x_last        = (x == X_LAST);
    assign eof           = bus.VideoReady & x_last & (y == Y_LAST);
    assign underflow_set = fb_grant & bus.VideoReady & ~bus.FbValid;

    // ---------------------------------------------------------------- raster
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x           <= '0;
            y           <= '0;
            frame_count <= '0;
        end else if (bus.VideoReady) begin
            if (x_last) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
            if (eof) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= S_PAT;
            fb_grant    <= 1'b0;
            pat_restart <= 1'b1;
        end else begin
            state       <= next_state;
            // Grant is registered from next_state, so it always matches state
            // and only changes on the edge that ends a frame.
            fb_grant    <= (next_state == S_FB) || (next_state == S_TO_PAT);
            // Pulse lands on the first cycle of the first pattern frame.
            pat_restart <= (state == S_TO_PAT) && (next_state == S_PAT);
        end
    end

    // NOTE: combinational blocks assign a default to every output first so no
    // path through the case can leave a value held (no inferred latch).
    always_comb begin
        next_state = state;
        case (state)
            S_PAT: begin
                if (bus.FbRequest) next_state = S_TO_FB;
            end
            S_TO_FB: begin
                // A dropped request aborts the hand-over before the frame ends.
                if (!bus.FbRequest) next_state = S_PAT;
                else if (eof)       next_state = S_FB;
            end
            S_FB: begin
                if (!bus.FbRequest) next_state = S_TO_PAT;
            end
            S_TO_PAT: begin
                // A returning request cancels the hand-back.
                if (bus.FbRequest)  next_state = S_FB;
                else if (eof)       next_state = S_PAT;
            end
            default: next_state = S_PAT;
        endcase
    end

    // ------------------------------------------------------------ underflow
    // Set has priority over clear so a simultaneous event is never lost.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            underflow <= 1'b0;
        end else if (underflow_set) begin
            underflow <= 1'b1;
        end else if (bus.ClearUnderflow) begin
            underflow <= 1'b0;
        end
    end

    // ----------------------------------------------------------- output mux
    always_comb begin
        bus.video    = bus.PatVideo;
        bus.PatReady = bus.VideoReady;
        bus.FbReady  = 1'b0;
        if (fb_grant) begin
            bus.PatReady = 1'b0;
            bus.FbReady  = bus.VideoReady & bus.FbValid;
            bus.video    = bus.FbValid ? bus.FbVideo : FILL_COLOR;
        end
    end

    assign bus.PatRestart = pat_restart;
    assign bus.FbGrant    = fb_grant;
    assign bus.FrameStart = (x == '0) && (y == '0);
    assign bus.Underflow  = underflow;
    assign bus.FrameCount = frame_count;

endmodule
